// File: rtl/status_register_pkg.sv
// Shared types and constants for the 6502 processor status register slice.
package status_register_pkg;

  // Explicit flag set/clear operations issued by the control unit.
  typedef enum logic [2:0] {
    FLAG_NONE = 3'd0,
    SEC       = 3'd1,
    CLC       = 3'd2,
    SEI       = 3'd3,
    CLI       = 3'd4,
    SED       = 3'd5,
    CLD       = 3'd6,
    CLV       = 3'd7
  } flag_op_t;

  // Bit positions of the flags within the P byte.
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  // Assemble a P byte from the six stored flags; bit5 always reads 1,
  // bit4 is supplied by the caller (constant 1 for p_out, push_brk for pushes).
  function automatic logic [7:0] format_p(
    input logic n,
    input logic v,
    input logic b,
    input logic d,
    input logic i,
    input logic z,
    input logic c
  );
    logic [7:0] p;
    p         = '0;
    p[FLAG_N] = n;
    p[FLAG_V] = v;
    p[5]      = 1'b1;
    p[FLAG_B] = b;
    p[FLAG_D] = d;
    p[FLAG_I] = i;
    p[FLAG_Z] = z;
    p[FLAG_C] = c;
    return p;
  endfunction

endpackage

// File: rtl/status_register_if.sv
// Bus between the ALU/control unit and the status register.
interface status_register_if;
  import status_register_pkg::*;

  logic       alu_negative;
  logic       alu_overflow;
  logic       alu_zero;
  logic       alu_carry;
  logic [7:0] data_in;
  logic       load_nz;
  logic       load_c;
  logic       load_v;
  logic       load_bus;
  logic       bit_test;
  flag_op_t   flag_op;
  logic       push_brk;
  logic [7:0] p_out;
  logic [7:0] push_value;
  logic       carry_to_alu;
  logic       decimal_mode;
  logic       irq_mask;

  // Control unit / ALU side.
  modport master (
    output alu_negative, alu_overflow, alu_zero, alu_carry,
    output data_in, load_nz, load_c, load_v, load_bus, bit_test,
    output flag_op, push_brk,
    input  p_out, push_value, carry_to_alu, decimal_mode, irq_mask
  );

  // Status register side.
  modport slave (
    input  alu_negative, alu_overflow, alu_zero, alu_carry,
    input  data_in, load_nz, load_c, load_v, load_bus, bit_test,
    input  flag_op, push_brk,
    output p_out, push_value, carry_to_alu, decimal_mode, irq_mask
  );

endinterface

// File: rtl/status_register_flag_bit.sv
// One status flag flop; owns the per-flag update priority for the whole register.
module status_flag_bit (
  input  logic clk,
  input  logic reset,
  input  logic rst_val_i,   // value taken on reset
  input  logic bus_load_i,  // PLP/RTI whole-register load
  input  logic bus_bit_i,
  input  logic set_i,       // explicit set from flag_op
  input  logic clr_i,       // explicit clear from flag_op
  input  logic pri_load_i,  // BIT instruction load
  input  logic pri_bit_i,
  input  logic sec_load_i,  // ALU result load
  input  logic sec_bit_i,
  output logic flag_o
);

  logic flag_q;
  logic flag_d;

  // Next value: bus load, then set/clear, then BIT, then ALU, else hold.
  always_comb begin
    flag_d = flag_q;
    if (bus_load_i) begin
      flag_d = bus_bit_i;
    end else if (set_i) begin
      flag_d = 1'b1;
    end else if (clr_i) begin
      flag_d = 1'b0;
    end else if (pri_load_i) begin
      flag_d = pri_bit_i;
    end else if (sec_load_i) begin
      flag_d = sec_bit_i;
    end
  end

  // Flag storage with synchronous reset overriding every load.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q <= rst_val_i;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/status_register.sv
// 6502 processor status register P (N V D I Z C), downstream of the ALU.
module status_register
  import status_register_pkg::*;
#(
  parameter logic [7:0] RESET_VALUE = 8'h34
) (
  input  logic              clk,
  input  logic              reset,
  status_register_if.slave  bus
);

  logic [7:0] set_v;
  logic [7:0] clr_v;
  logic       n_q, v_q, d_q, i_q, z_q, c_q;

  // Decode flag_op into per-bit set/clear strobes.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    unique case (bus.flag_op)
      SEC:     set_v[FLAG_C] = 1'b1;
      CLC:     clr_v[FLAG_C] = 1'b1;
      SEI:     set_v[FLAG_I] = 1'b1;
      CLI:     clr_v[FLAG_I] = 1'b1;
      SED:     set_v[FLAG_D] = 1'b1;
      CLD:     clr_v[FLAG_D] = 1'b1;
      CLV:     clr_v[FLAG_V] = 1'b1;
      default: ;
    endcase
  end

  status_flag_bit u_flag_n (
    .clk        (clk),
    .reset      (reset),
    .rst_val_i  (RESET_VALUE[FLAG_N]),
    .bus_load_i (bus.load_bus),
    .bus_bit_i  (bus.data_in[FLAG_N]),
    .set_i      (set_v[FLAG_N]),
    .clr_i      (clr_v[FLAG_N]),
    .pri_load_i (bus.bit_test),
    .pri_bit_i  (bus.data_in[7]),
    .sec_load_i (bus.load_nz),
    .sec_bit_i  (bus.alu_negative),
    .flag_o     (n_q)
  );

  status_flag_bit u_flag_v (
    .clk        (clk),
    .reset      (reset),
    .rst_val_i  (RESET_VALUE[FLAG_V]),
    .bus_load_i (bus.load_bus),
    .bus_bit_i  (bus.data_in[FLAG_V]),
    .set_i      (set_v[FLAG_V]),
    .clr_i      (clr_v[FLAG_V]),
    .pri_load_i (bus.bit_test),
    .pri_bit_i  (bus.data_in[6]),
    .sec_load_i (bus.load_v),
    .sec_bit_i  (bus.alu_overflow),
    .flag_o     (v_q)
  );

  status_flag_bit u_flag_d (
    .clk        (clk),
    .reset      (reset),
    .rst_val_i  (RESET_VALUE[FLAG_D]),
    .bus_load_i (bus.load_bus),
    .bus_bit_i  (bus.data_in[FLAG_D]),
    .set_i      (set_v[FLAG_D]),
    .clr_i      (clr_v[FLAG_D]),
    .pri_load_i (1'b0),
    .pri_bit_i  (1'b0),
    .sec_load_i (1'b0),
    .sec_bit_i  (1'b0),
    .flag_o     (d_q)
  );

  // I always comes out of reset set, whatever RESET_VALUE says.
  status_flag_bit u_flag_i (
    .clk        (clk),
    .reset      (reset),
    .rst_val_i  (1'b1),
    .bus_load_i (bus.load_bus),
    .bus_bit_i  (bus.data_in[FLAG_I]),
    .set_i      (set_v[FLAG_I]),
    .clr_i      (clr_v[FLAG_I]),
    .pri_load_i (1'b0),
    .pri_bit_i  (1'b0),
    .sec_load_i (1'b0),
    .sec_bit_i  (1'b0),
    .flag_o     (i_q)
  );

  // BIT drives Z from the ALU zero result, same source as load_nz.
  status_flag_bit u_flag_z (
    .clk        (clk),
    .reset      (reset),
    .rst_val_i  (RESET_VALUE[FLAG_Z]),
    .bus_load_i (bus.load_bus),
    .bus_bit_i  (bus.data_in[FLAG_Z]),
    .set_i      (set_v[FLAG_Z]),
    .clr_i      (clr_v[FLAG_Z]),
    .pri_load_i (bus.bit_test),
    .pri_bit_i  (bus.alu_zero),
    .sec_load_i (bus.load_nz),
    .sec_bit_i  (bus.alu_zero),
    .flag_o     (z_q)
  );

  status_flag_bit u_flag_c (
    .clk        (clk),
    .reset      (reset),
    .rst_val_i  (RESET_VALUE[FLAG_C]),
    .bus_load_i (bus.load_bus),
    .bus_bit_i  (bus.data_in[FLAG_C]),
    .set_i      (set_v[FLAG_C]),
    .clr_i      (clr_v[FLAG_C]),
    .pri_load_i (1'b0),
    .pri_bit_i  (1'b0),
    .sec_load_i (bus.load_c),
    .sec_bit_i  (bus.alu_carry),
    .flag_o     (c_q)
  );

  // Bits 5/4 are not stored; bus bits 5/4 and the matching strobes are dropped.
  logic unused_bits;
  assign unused_bits = ^{bus.data_in[5:4], set_v[5:4], clr_v[5:4]};

  assign bus.p_out        = format_p(n_q, v_q, 1'b1, d_q, i_q, z_q, c_q);
  assign bus.push_value   = format_p(n_q, v_q, bus.push_brk, d_q, i_q, z_q, c_q);
  assign bus.carry_to_alu = c_q;
  assign bus.decimal_mode = d_q;
  assign bus.irq_mask     = i_q;

endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register against a byte-level model of P.
module tb_status_register;
  import status_register_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   errors;
  logic [7:0] mdl;

  status_register_if sif ();

  status_register #(.RESET_VALUE(8'h34)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset            = 1'b0;
    sif.alu_negative = 1'b0;
    sif.alu_overflow = 1'b0;
    sif.alu_zero     = 1'b0;
    sif.alu_carry    = 1'b0;
    sif.data_in      = 8'h00;
    sif.load_nz      = 1'b0;
    sif.load_c       = 1'b0;
    sif.load_v       = 1'b0;
    sif.load_bus     = 1'b0;
    sif.bit_test     = 1'b0;
    sif.flag_op      = FLAG_NONE;
    sif.push_brk     = 1'b1;
  endtask

  // One clock edge; the model applies the lowest-priority rules first and lets
  // higher-priority ones overwrite them.
  task automatic step();
    logic [7:0] nx;
    @(posedge clk);
    if (reset) begin
      nx = 8'h34;
    end else if (sif.load_bus) begin
      nx = sif.data_in | 8'h30;
    end else begin
      nx = mdl;
      if (sif.load_nz) begin nx[7] = sif.alu_negative; nx[1] = sif.alu_zero; end
      if (sif.load_c)  nx[0] = sif.alu_carry;
      if (sif.load_v)  nx[6] = sif.alu_overflow;
      if (sif.bit_test) begin
        nx[7] = sif.data_in[7];
        nx[6] = sif.data_in[6];
        nx[1] = sif.alu_zero;
      end
      case (sif.flag_op)
        SEC: nx[0] = 1'b1;
        CLC: nx[0] = 1'b0;
        SEI: nx[2] = 1'b1;
        CLI: nx[2] = 1'b0;
        SED: nx[3] = 1'b1;
        CLD: nx[3] = 1'b0;
        CLV: nx[6] = 1'b0;
        default: ;
      endcase
    end
    mdl = nx;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (sif.p_out !== 8'h34) begin errors++; $display("FAIL reset_p_out got %h exp 34", sif.p_out); end
    vectors++;
    if (sif.irq_mask !== 1'b1) begin errors++; $display("FAIL reset_irq_mask got %b exp 1", sif.irq_mask); end
    vectors++;
    if (sif.carry_to_alu !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", sif.carry_to_alu); end
    vectors++;
    if (sif.decimal_mode !== 1'b0) begin errors++; $display("FAIL reset_decimal got %b exp 0", sif.decimal_mode); end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (sif.p_out !== 8'h34) begin errors++; $display("FAIL reset_hold got %h exp 34", sif.p_out); end
    end
  endtask

  task automatic test_alu_load();
    idle();
    sif.alu_negative = 1'b1;
    sif.alu_zero     = 1'b0;
    sif.alu_carry    = 1'b1;
    sif.load_nz      = 1'b1;
    sif.load_c       = 1'b1;
    step();
    vectors++;
    if (sif.p_out !== 8'hB5) begin errors++; $display("FAIL alu_load got %h exp b5", sif.p_out); end
    idle();
    sif.alu_negative = 1'b0;
    sif.alu_zero     = 1'b1;
    sif.alu_carry    = 1'b0;
    sif.alu_overflow = 1'b1;
    step();
    vectors++;
    if (sif.p_out !== 8'hB5) begin errors++; $display("FAIL alu_hold got %h exp b5", sif.p_out); end
  endtask

  task automatic test_bus_priority();
    idle();
    sif.load_bus  = 1'b1;
    sif.data_in   = 8'hCF;
    sif.flag_op   = CLC;
    sif.load_c    = 1'b1;
    sif.alu_carry = 1'b0;
    step();
    idle();
    vectors++;
    if (sif.p_out !== 8'hFF) begin errors++; $display("FAIL bus_load got %h exp ff", sif.p_out); end
    sif.push_brk = 1'b0;
    #1;
    vectors++;
    if (sif.push_value !== 8'hEF) begin errors++; $display("FAIL push_irq got %h exp ef", sif.push_value); end
    sif.push_brk = 1'b1;
    #1;
    vectors++;
    if (sif.push_value !== 8'hFF) begin errors++; $display("FAIL push_brk got %h exp ff", sif.push_value); end
  endtask

  task automatic test_bit_test();
    idle();
    reset = 1'b1;
    step();
    idle();
    sif.bit_test = 1'b1;
    sif.data_in  = 8'h40;
    sif.alu_zero = 1'b1;
    sif.flag_op  = CLV;
    step();
    vectors++;
    if (sif.p_out !== 8'h36) begin errors++; $display("FAIL bit_clv got %h exp 36", sif.p_out); end
    sif.flag_op = FLAG_NONE;
    step();
    vectors++;
    if (sif.p_out !== 8'h76) begin errors++; $display("FAIL bit_none got %h exp 76", sif.p_out); end
  endtask

  task automatic test_flag_ops();
    logic [7:0] exp_seq [3];
    flag_op_t   ops     [3];
    exp_seq = '{8'h3C, 8'h3D, 8'h39};
    ops     = '{SED, SEC, CLI};
    idle();
    reset = 1'b1;
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      sif.flag_op = ops[k];
      step();
      vectors++;
      if (sif.p_out !== exp_seq[k]) begin
        errors++; $display("FAIL flag_op_%0d got %h exp %h", k, sif.p_out, exp_seq[k]);
      end
    end
    idle();
    vectors++;
    if (sif.decimal_mode !== 1'b1) begin errors++; $display("FAIL flag_decimal got %b exp 1", sif.decimal_mode); end
    vectors++;
    if (sif.carry_to_alu !== 1'b1) begin errors++; $display("FAIL flag_carry got %b exp 1", sif.carry_to_alu); end
    vectors++;
    if (sif.irq_mask !== 1'b0) begin errors++; $display("FAIL flag_irq got %b exp 0", sif.irq_mask); end
  endtask

  task automatic test_reset_priority();
    idle();
    reset        = 1'b1;
    sif.load_bus = 1'b1;
    sif.data_in  = 8'h00;
    sif.flag_op  = SEC;
    step();
    idle();
    vectors++;
    if (sif.p_out !== 8'h34) begin errors++; $display("FAIL reset_over_bus got %h exp 34", sif.p_out); end
  endtask

  task automatic test_random();
    logic [7:0] exp_push;
    for (int k = 0; k < 400; k++) begin
      reset            = ($urandom_range(0, 31) == 0);
      sif.alu_negative = 1'($urandom);
      sif.alu_overflow = 1'($urandom);
      sif.alu_zero     = 1'($urandom);
      sif.alu_carry    = 1'($urandom);
      sif.data_in      = 8'($urandom);
      sif.load_nz      = ($urandom_range(0, 2) == 0);
      sif.load_c       = ($urandom_range(0, 2) == 0);
      sif.load_v       = ($urandom_range(0, 2) == 0);
      sif.load_bus     = ($urandom_range(0, 7) == 0);
      sif.bit_test     = ($urandom_range(0, 3) == 0);
      sif.flag_op      = flag_op_t'($urandom_range(0, 7));
      sif.push_brk     = 1'($urandom);
      step();
      exp_push = {mdl[7:6], 1'b1, sif.push_brk, mdl[3:0]};
      vectors++;
      if (sif.p_out !== mdl) begin
        errors++; $display("FAIL rand_p_out cyc %0d got %h exp %h", k, sif.p_out, mdl);
      end
      vectors++;
      if (sif.push_value !== exp_push) begin
        errors++; $display("FAIL rand_push cyc %0d got %h exp %h", k, sif.push_value, exp_push);
      end
      vectors++;
      if ({sif.carry_to_alu, sif.decimal_mode, sif.irq_mask} !== {mdl[0], mdl[3], mdl[2]}) begin
        errors++;
        $display("FAIL rand_flags cyc %0d got c%b d%b i%b exp c%b d%b i%b", k,
                 sif.carry_to_alu, sif.decimal_mode, sif.irq_mask, mdl[0], mdl[3], mdl[2]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    mdl     = 8'h00;
    idle();
    @(negedge clk);
    test_reset();
    test_alu_load();
    test_bus_priority();
    test_bit_test();
    test_flag_ops();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/status_register.md
Name: status_register

Overview:
- Holds the 6502 processor status register P, stored bits N V D I Z C, and sits directly downstream of the ALU.
- Latches the ALU flag outputs (negative, overflow, zero, carry) under per-group update enables from the control unit.
- Also serves the PLP/RTI bus load, the BIT instruction, and the SEC/CLC/SEI/CLI/SED/CLD/CLV set/clear operations.
- Feeds the stored carry back to the ALU `carry_in` and supplies the formatted byte pushed to the stack.

Parameters:
- RESET_VALUE, 8'h34: value presented on `p_out` after reset (I=1, bit5=1, B=1, all others 0).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- alu_negative  input  1  ALU `negative_out`
- alu_overflow  input  1  ALU `overflow_out`
- alu_zero  input  1  ALU `zero_out`
- alu_carry  input  1  ALU `carry_out`
- data_in  input  8  internal data bus; used for the PLP/RTI load and the BIT operand
- load_nz  input  1  update N and Z from the ALU
- load_c  input  1  update C from the ALU
- load_v  input  1  update V from the ALU
- load_bus  input  1  load the whole of P from `data_in`
- bit_test  input  1  BIT: N<=data_in[7], V<=data_in[6], Z<=alu_zero
- flag_op  input  3  `control_signals::flag_op_t`: FLAG_NONE, SEC, CLC, SEI, CLI, SED, CLD, CLV
- push_brk  input  1  value placed in bit4 of `push_value` (1 for PHP/BRK, 0 for IRQ/NMI)
- p_out  output  8  {N,V,1,1,D,I,Z,C}
- push_value  output  8  {N,V,1,push_brk,D,I,Z,C}
- carry_to_alu  output  1  stored C, wired to the ALU `carry_in`
- decimal_mode  output  1  stored D
- irq_mask  output  1  stored I

Behaviour:
- Storage: six flops, N V D I Z C. Bits 5 and 4 are not stored and are constant in `p_out`.
- Reset (synchronous, highest priority): N V D Z C <= RESET_VALUE bits; I <= 1.
  - After reset, `p_out` = 8'h34, `carry_to_alu` = 0, `decimal_mode` = 0, `irq_mask` = 1.
  - Reset asserted together with any load: reset wins and every load is ignored that cycle.
- Outputs are pure combinational decodes of the stored flops. Latency is one cycle: a value applied at edge k is visible right after edge k.
- Per-flag priority within a cycle, highest first:
  1. `reset`
  2. `load_bus`: all six flags from `data_in` {7,6,3,2,1,0}; `data_in` bits 5 and 4 are discarded
  3. `flag_op` targeting that flag
  4. `bit_test`, for N, V, Z
  5. `load_nz` / `load_c` / `load_v`
  6. hold
- Non-conflicting updates in the same cycle all apply.
  - Example: `load_nz` with `flag_op`=SEC updates N, Z and C together.
  - Example: `bit_test` with `load_c` updates N, V, Z and C together.
- `load_bus` active: `flag_op` and all ALU loads are ignored for every flag, not only the conflicting ones.
- Undefined `flag_op` encodings behave as FLAG_NONE.
- D has no arithmetic effect here. `decimal_mode` is exported only for the ALU/control unit.
- No handshake: all enables are single-cycle strobes from the control unit. A strobe held high re-applies the update every cycle.

Decomposition:
- `flag_op_t` enum (3 bits) goes in the existing `control_signals` package next to `alu_op_t`.
- Flag bit-index constants also go in `control_signals`: FLAG_C=0, FLAG_Z=1, FLAG_I=2, FLAG_D=3, FLAG_B=4, FLAG_V=6, FLAG_N=7.
- One sub-module: `status_flag_bit`.
  - A single flop with priority mux; inputs are reset value, bus bit, set, clear, primary load, secondary load.
  - Instantiated six times.
  - Keeps the priority ordering in one place.

Test Plan:
- Reset for 1 cycle, then release -> `p_out`=8'h34, `irq_mask`=1, `carry_to_alu`=0; holds with all enables low.
- `alu_negative`=1, `alu_zero`=0, `alu_carry`=1, `load_nz`=1, `load_c`=1 for one cycle -> `p_out`=8'hB5; next cycle with `load_nz`=0, `load_c`=0 and the ALU inputs changed -> 8'hB5 retained.
- `load_bus`=1 with `data_in`=8'hCF, `flag_op`=CLC and `load_c`=1 all in the same cycle -> `p_out`=8'hFF (bus wins, bits 5/4 read 1); then `push_brk`=0 -> `push_value`=8'hEF.
- From `p_out`=8'h34: `bit_test`=1, `data_in`=8'h40, `alu_zero`=1 together with `flag_op`=CLV -> V=0, N=0, Z=1, `p_out`=8'h36; repeat with `flag_op`=FLAG_NONE -> `p_out`=8'h76.
- `flag_op` sequence SED, SEC, CLI -> `p_out` 8'h3C, then 8'h3D, then 8'h39; `decimal_mode`=1, `carry_to_alu`=1, `irq_mask`=0.
- Reset asserted mid-sequence together with `load_bus`=1 and `data_in`=8'h00 -> `p_out`=8'h34 after that edge.
